// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial UART transmit path.
package serial_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Count must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/serial_sync_fifo.sv
// Synchronous FIFO with registered count, empty and ready (not-full) flags.
module serial_sync_fifo
    import serial_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_c,
    output logic                         ready,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic [cnt_width(DEPTH)-1:0]  count_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Flags follow the count so simultaneous push/pop leaves them unchanged.
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign head_c      = mem_q[rd_ptr_q];
    assign ready       = !full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/serial_uart_tx.sv
// UART transmit serialiser: buffered bytes shifted out as 8N1/8N2 frames on txd.
module serial_uart_tx
    import serial_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic                              tx_enable,
    output logic                              txd,
    output logic                              tx_busy,
    output logic                              tx_empty,
    output logic [cnt_width(FIFO_DEPTH)-1:0]  fifo_count
);

    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

    uart_state_t          state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 empty_q, empty_d;

    logic                 pop_c;
    logic [7:0]           fifo_head_c;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count_nxt_c;
    logic                 bit_end;
    logic                 start_ok;

    serial_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (ACLK),
        .rst         (ARESET),
        .push        (tx_valid),
        .wr_data     (tx_data),
        .pop         (pop_c),
        .head_c      (fifo_head_c),
        .ready       (tx_ready),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .count_nxt_c (fifo_count_nxt_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        pop_c    = 1'b0;
        bit_end  = (cnt_q == div_q);
        start_ok = tx_enable && !fifo_empty;

        unique case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (start_ok) begin
                    state_d = START;
                    pop_c   = 1'b1;
                    shift_d = fifo_head_c;
                    div_d   = baud_div;
                    cnt_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        if (start_ok) begin
                            state_d = START;
                            pop_c   = 1'b1;
                            shift_d = fifo_head_c;
                            div_d   = baud_div;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        empty_d = (state_d == IDLE) && (fifo_count_nxt_c == '0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            empty_q <= empty_d;
        end
    end

    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_empty = empty_q;

endmodule

// File: tb/tb_serial_uart_tx.sv
// Self-checking bench for serial_uart_tx: directed scenarios plus randomized traffic vs a frame model.
module tb_serial_uart_tx;

    logic        ACLK;
    logic        ARESET;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] baud_div;
    logic        tx_enable;
    logic        txd;
    logic        tx_busy;
    logic        tx_empty;
    logic [4:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    serial_uart_tx #(
        .FIFO_DEPTH (16),
        .STOP_BITS  (1),
        .DIV_W      (16)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .baud_div   (baud_div),
        .tx_enable  (tx_enable),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_empty   (tx_empty),
        .fifo_count (fifo_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    // Reference frame: start bit, 8 data bits LSB first, one stop bit, each div+1 cycles.
    task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0] bits;
        logic       ok;
        int         waited;
        bits   = {1'b1, b, 1'b0};
        waited = 0;
        while (txd !== 1'b0 && waited < 2000) begin
            tick();
            waited++;
        end
        if (txd !== 1'b0) begin
            check_eq({tag, "_start_timeout"}, 32'(txd), 32'd0);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            for (int c = 0; c <= div; c++) begin
                if (txd !== bits[k] || tx_busy !== 1'b1) ok = 1'b0;
                tick();
            end
            check_eq($sformatf("%s_bit%0d", tag, k), 32'(ok), 32'd1);
        end
    endtask

    task automatic expect_idle(input int cycles, input string tag);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (txd !== 1'b1) ok = 1'b0;
            tick();
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [7:0] rnd_bytes [16];
        int         rnd_n;
        int         rnd_div;

        ARESET    = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        baud_div  = 16'd3;
        tx_enable = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        check_eq("rst_txd",   32'(txd),        32'd1);
        check_eq("rst_busy",  32'(tx_busy),    32'd0);
        check_eq("rst_empty", 32'(tx_empty),   32'd1);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_ready", 32'(tx_ready),   32'd1);

        // Single byte, latency and busy window
        push(8'h55);
        check_eq("single_cnt1", 32'(fifo_count), 32'd1);
        check_eq("single_txd1", 32'(txd),        32'd1);
        tick();
        check_eq("single_fall", 32'(txd),        32'd0);
        check_eq("single_cnt0", 32'(fifo_count), 32'd0);
        check_eq("single_busy", 32'(tx_busy),    32'd1);
        expect_frame(8'h55, 3, "single");
        check_eq("single_busy_end",  32'(tx_busy),  32'd0);
        check_eq("single_empty_end", 32'(tx_empty), 32'd1);
        check_eq("single_txd_end",   32'(txd),      32'd1);

        // Overflow with transmission held off
        tx_enable = 1'b0;
        baud_div  = 16'd0;
        for (int i = 0; i < 16; i++) push(8'(i));
        check_eq("ovf_cnt16",  32'(fifo_count), 32'd16);
        check_eq("ovf_ready0", 32'(tx_ready),   32'd0);
        push(8'h10);
        check_eq("ovf_cnt_after17", 32'(fifo_count), 32'd16);
        check_eq("ovf_txd_held",    32'(txd),        32'd1);
        tx_enable = 1'b1;
        for (int i = 0; i < 16; i++) expect_frame(8'(i), 0, $sformatf("ovf%0d", i));
        expect_idle(20, "ovf_no_17th");
        check_eq("ovf_empty", 32'(tx_empty), 32'd1);

        // Back-to-back at the fastest bit rate
        tx_enable = 1'b0;
        push(8'h00);
        push(8'hFF);
        tx_enable = 1'b1;
        expect_frame(8'h00, 0, "b2b_a");
        check_eq("b2b_no_gap", 32'(txd), 32'd0);
        expect_frame(8'hFF, 0, "b2b_b");
        check_eq("b2b_busy_end", 32'(tx_busy), 32'd0);

        // Divisor change mid-frame applies only to the next frame
        tx_enable = 1'b0;
        baud_div  = 16'd7;
        push(8'hA3);
        push(8'h3C);
        tx_enable = 1'b1;
        fork
            expect_frame(8'hA3, 7, "div_a");
            begin
                repeat (30) tick();
                baud_div = 16'd1;
            end
        join
        expect_frame(8'h3C, 1, "div_b");

        // Enable gating mid-frame
        tx_enable = 1'b0;
        baud_div  = 16'd2;
        push(8'h81);
        push(8'h42);
        push(8'hC7);
        tx_enable = 1'b1;
        fork
            expect_frame(8'h81, 2, "gate_a");
            begin
                repeat (15) tick();
                tx_enable = 1'b0;
            end
        join
        expect_idle(25, "gate_hold");
        check_eq("gate_cnt2", 32'(fifo_count), 32'd2);
        check_eq("gate_busy", 32'(tx_busy),    32'd0);
        tx_enable = 1'b1;
        expect_frame(8'h42, 2, "gate_b");
        expect_frame(8'hC7, 2, "gate_c");

        // Reset during DATA bit 4 of 0xF0 with two more bytes queued
        tx_enable = 1'b0;
        baud_div  = 16'd1;
        push(8'hF0);
        push(8'h11);
        push(8'h22);
        tx_enable = 1'b1;
        tick();
        check_eq("rstmid_fall", 32'(txd), 32'd0);
        repeat (10) tick();
        check_eq("rstmid_bit4", 32'(txd), 32'd1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check_eq("rstmid_txd",   32'(txd),        32'd1);
        check_eq("rstmid_count", 32'(fifo_count), 32'd0);
        check_eq("rstmid_busy",  32'(tx_busy),    32'd0);
        check_eq("rstmid_empty", 32'(tx_empty),   32'd1);
        expect_idle(60, "rstmid_no_frames");

        // Randomized rounds: bursts up to FIFO depth at a random divisor
        for (int r = 0; r < 12; r++) begin
            rnd_n    = $urandom_range(16, 1);
            rnd_div  = $urandom_range(3, 0);
            baud_div = 16'(rnd_div);
            for (int i = 0; i < rnd_n; i++) rnd_bytes[i] = 8'($urandom);
            fork
                begin
                    for (int i = 0; i < rnd_n; i++) begin
                        repeat ($urandom_range(5, 0)) tick();
                        check_eq("rnd_ready", 32'(tx_ready), 32'd1);
                        push(rnd_bytes[i]);
                    end
                end
                begin
                    for (int i = 0; i < rnd_n; i++)
                        expect_frame(rnd_bytes[i], rnd_div, $sformatf("rnd%0d_%0d", r, i));
                end
            join
            tick();
            check_eq("rnd_empty", 32'(tx_empty),   32'd1);
            check_eq("rnd_count", 32'(fifo_count), 32'd0);
            check_eq("rnd_txd",   32'(txd),        32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
